// File: rtl/census_transform.sv
// census_transform
//
// Census-transform stage placed directly after the line buffer in the stereo
// path. For every accepted pixel, the line buffer presents a flat window of
// NUM_LINES x WINDOW_WIDTH pixels. This block compares each non-centre pixel
// with the centre pixel and emits one census bit per non-centre pixel.
// Row and column counters follow the position of the newest pixel, so that
// only windows lying fully inside the frame are flagged valid.
//
// Ports
//   clk      : single clock, rising edge
//   rst      : asynchronous reset, active low
//   en       : pixel accept strobe (the same enable that drives the line buffer)
//   sof      : start of frame, qualified by en; marks pixel (0,0)
//   win      : flat window; pixel p occupies bits [WIDTH*(p+1)-1 : WIDTH*p]
//   census   : CW-bit census vector; holds its value between valid windows
//   valid    : one-cycle pulse; census holds a complete in-frame window
//   sof_out  : with valid, marks the first valid window of a frame
//   eol_out  : with valid, marks the last valid window of a line
module census_transform #(
  parameter  int WIDTH        = 8,
  parameter  int LINE_LENGTH  = 320,
  parameter  int NUM_LINES    = 5,
  parameter  int WINDOW_WIDTH = 5,
  parameter  int NUM_ROWS     = 240,
  localparam int N            = NUM_LINES * WINDOW_WIDTH,
  localparam int CW           = N - 1,
  localparam int C            = N / 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 sof,
  input  logic [WIDTH*N-1:0]   win,
  output logic [CW-1:0]        census,
  output logic                 valid,
  output logic                 sof_out,
  output logic                 eol_out
);

  localparam int COL_W = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;
  localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(LINE_LENGTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(NUM_ROWS - 1);
  localparam logic [COL_W-1:0] COL_FIRST = COL_W'(WINDOW_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(NUM_LINES - 1);

  // Bit b compares pixel q (q skips the centre) against the centre pixel.
  // It is set when the pixel is strictly below the centre, unsigned.
  function automatic logic [CW-1:0] census_bits(input logic [WIDTH*N-1:0] w);
    logic [CW-1:0]    r;
    logic [WIDTH-1:0] ctr;
    logic [WIDTH-1:0] px;
    r   = '0;
    ctr = w[WIDTH*C +: WIDTH];
    for (int b = 0; b < CW; b++) begin
      px   = w[WIDTH*((b < C) ? b : b + 1) +: WIDTH];
      r[b] = (px < ctr);
    end
    return r;
  endfunction

  logic              en_d_q, en_d_d;
  logic              sof_d_q, sof_d_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  cur_row;
  logic [COL_W-1:0]  cur_col;
  logic              in_frame;

  logic [CW-1:0]     cmp_p1_q, cmp_p1_d;
  logic              vld_p1_q, vld_p1_d;
  logic              sof_p1_q, sof_p1_d;
  logic              eol_p1_q, eol_p1_d;

  logic [CW-1:0]     census_p2_q, census_p2_d;
  logic              vld_p2_q, vld_p2_d;
  logic              sof_p2_q, sof_p2_d;
  logic              eol_p2_q, eol_p2_d;

  always_comb begin
    en_d_d  = en;
    sof_d_d = en & sof;

    // row_q/col_q hold the position the next sampled pixel will take.
    // A registered sof forces the current pixel to (0,0).
    cur_row = sof_d_q ? '0 : row_q;
    cur_col = sof_d_q ? '0 : col_q;

    row_d = row_q;
    col_d = col_q;
    if (en_d_q) begin
      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = (cur_row == ROW_LAST) ? '0 : cur_row + ROW_W'(1);
      end else begin
        col_d = cur_col + COL_W'(1);
        row_d = cur_row;
      end
    end

    // Windows that straddle a line wrap, or that still hold rows from the
    // previous frame, fail this test.
    in_frame = (cur_row >= ROW_FIRST) && (cur_col >= COL_FIRST);

    // Stage 1: comparisons and window flags for the sampled window
    cmp_p1_d = en_d_q ? census_bits(win) : cmp_p1_q;
    vld_p1_d = en_d_q & in_frame;
    sof_p1_d = en_d_q & in_frame & (cur_row == ROW_FIRST) & (cur_col == COL_FIRST);
    eol_p1_d = en_d_q & in_frame & (cur_col == COL_LAST);

    // Stage 2: output registers; census holds between valid windows
    census_p2_d = vld_p1_q ? cmp_p1_q : census_p2_q;
    vld_p2_d    = vld_p1_q;
    sof_p2_d    = vld_p1_q & sof_p1_q;
    eol_p2_d    = vld_p1_q & eol_p1_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_d_q      <= 1'b0;
      sof_d_q     <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      cmp_p1_q    <= '0;
      vld_p1_q    <= 1'b0;
      sof_p1_q    <= 1'b0;
      eol_p1_q    <= 1'b0;
      census_p2_q <= '0;
      vld_p2_q    <= 1'b0;
      sof_p2_q    <= 1'b0;
      eol_p2_q    <= 1'b0;
    end else begin
      en_d_q      <= en_d_d;
      sof_d_q     <= sof_d_d;
      row_q       <= row_d;
      col_q       <= col_d;
      cmp_p1_q    <= cmp_p1_d;
      vld_p1_q    <= vld_p1_d;
      sof_p1_q    <= sof_p1_d;
      eol_p1_q    <= eol_p1_d;
      census_p2_q <= census_p2_d;
      vld_p2_q    <= vld_p2_d;
      sof_p2_q    <= sof_p2_d;
      eol_p2_q    <= eol_p2_d;
    end
  end

  assign census  = census_p2_q;
  assign valid   = vld_p2_q;
  assign sof_out = sof_p2_q;
  assign eol_out = eol_p2_q;

endmodule

// File: tb/tb_census_transform.sv
// Testbench for census_transform: a small frame geometry, a position and
// census model kept in the bench, a per-cycle compare process, and directed
// scenarios with literal expectations.
module tb_census_transform;
  localparam int WIDTH = 8;
  localparam int LL    = 8;
  localparam int NL    = 3;
  localparam int WW    = 3;
  localparam int NR    = 4;
  localparam int N     = NL * WW;
  localparam int CW    = N - 1;
  localparam int DEPTH = 2048;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en;
  logic                 sof;
  logic [WIDTH*N-1:0]   win;
  logic [CW-1:0]        census;
  logic                 valid;
  logic                 sof_out;
  logic                 eol_out;

  census_transform #(
    .WIDTH(WIDTH), .LINE_LENGTH(LL), .NUM_LINES(NL),
    .WINDOW_WIDTH(WW), .NUM_ROWS(NR)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .sof(sof), .win(win),
    .census(census), .valid(valid), .sof_out(sof_out), .eol_out(eol_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected outputs indexed by the cycle in which they must be visible.
  bit       exp_v [DEPTH];
  bit [7:0] exp_c [DEPTH];
  bit       exp_s [DEPTH];
  bit       exp_e [DEPTH];
  bit [7:0] model_census = 8'h00;
  int       knext = 0;

  function automatic bit [7:0] model_census_of(input logic [WIDTH*N-1:0] w);
    int pix [N];
    bit [7:0] r;
    int q;
    for (int p = 0; p < N; p++) pix[p] = int'(w[8*p +: 8]);
    r = '0;
    for (int b = 0; b < CW; b++) begin
      q = (b < N/2) ? b : b + 1;
      r[b] = (pix[q] < pix[N/2]);
    end
    return r;
  endfunction

  // k counts pixels since the last frame start; the position follows from it.
  task automatic model_pixel(input int t, input bit s, input logic [WIDTH*N-1:0] w);
    int k, row, col;
    k = s ? 0 : knext;
    knext = k + 1;
    row = (k / LL) % NR;
    col = k % LL;
    if (t + 3 < DEPTH && row >= NL-1 && col >= WW-1) begin
      exp_v[t+3] = 1'b1;
      exp_c[t+3] = model_census_of(w);
      exp_s[t+3] = (row == NL-1) && (col == WW-1);
      exp_e[t+3] = (col == LL-1);
    end
  endtask

  // Stimulus: win follows en by one cycle, like the line buffer output.
  logic [WIDTH*N-1:0] pend_w;
  bit                 pend = 1'b0;
  int                 en_cyc [128];
  int                 ne = 0;

  task automatic tick(input bit e, input bit s, input logic [WIDTH*N-1:0] w);
    @(posedge clk); #1;
    if (pend) win = pend_w;
    pend = 1'b0;
    en  = e;
    sof = s;
    if (e) begin
      pend   = 1'b1;
      pend_w = w;
      model_pixel(cyc, s, w);
      if (ne < 128) en_cyc[ne] = cyc;
      ne++;
    end
  endtask

  task automatic drain();
    repeat (5) tick(1'b0, 1'b0, '0);
  endtask

  function automatic logic [WIDTH*N-1:0] win_flat(input int v);
    logic [WIDTH*N-1:0] w;
    for (int p = 0; p < N; p++) w[8*p +: 8] = 8'(v);
    return w;
  endfunction

  function automatic logic [WIDTH*N-1:0] win_ramp(input bit rev);
    logic [WIDTH*N-1:0] w;
    for (int p = 0; p < N; p++) w[8*p +: 8] = rev ? 8'(80 - 10*p) : 8'(10*p);
    return w;
  endfunction

  function automatic logic [WIDTH*N-1:0] win_rand();
    logic [WIDTH*N-1:0] w;
    for (int p = 0; p < N; p++) w[8*p +: 8] = 8'($urandom_range(0, 15));
    return w;
  endfunction

  // Recorded output pulses of the current scenario.
  int       np = 0;
  int       p_cyc [64];
  bit [7:0] p_cen [64];
  bit       p_sof [64];
  bit       p_eol [64];

  initial begin
    forever begin
      @(negedge clk);
      if (cyc < DEPTH) begin
        if (exp_v[cyc]) model_census = exp_c[cyc];
        chk("valid",   valid,   exp_v[cyc]);
        chk("sof_out", sof_out, exp_s[cyc]);
        chk("eol_out", eol_out, exp_e[cyc]);
        chk("census",  census,  model_census);
      end
      if (valid === 1'b1 && np < 64) begin
        p_cyc[np] = cyc;
        p_cen[np] = census;
        p_sof[np] = sof_out;
        p_eol[np] = eol_out;
        np++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  int idx, j;

  initial begin
    rst = 1'b0; en = 1'b0; sof = 1'b0; win = '0;
    #3;
    chk("rst_valid",   valid,   0);
    chk("rst_census",  census,  0);
    chk("rst_sof_out", sof_out, 0);
    chk("rst_eol_out", eol_out, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Flat window: every pixel 10, one frame back-to-back
    ne = 0; np = 0;
    for (int i = 0; i < 32; i++) tick(1'b1, i == 0, win_flat(10));
    drain();
    chk("flat_count",     np, 12);
    chk("flat_first_cyc", p_cyc[0], en_cyc[18] + 3);
    chk("flat_first_sof", p_sof[0], 1);
    chk("flat_eol_5",     p_eol[4], 0);
    chk("flat_eol_6",     p_eol[5], 1);
    chk("flat_eol_12",    p_eol[11], 1);
    chk("flat_census_0",  p_cen[0], 8'h00);
    chk("flat_census_11", p_cen[11], 8'h00);

    // Ramp on the first 24 pixels, reversed ramp afterwards
    ne = 0; np = 0;
    for (int i = 0; i < 32; i++) tick(1'b1, i == 0, win_ramp(i >= 24));
    drain();
    chk("ramp_count", np, 12);
    chk("ramp_up_0",  p_cen[0], 8'h0F);
    chk("ramp_up_5",  p_cen[5], 8'h0F);
    chk("ramp_dn_6",  p_cen[6], 8'hF0);
    chk("ramp_dn_11", p_cen[11], 8'hF0);

    // Sparse enable: en every other cycle
    ne = 0; np = 0;
    for (int i = 0; i < 32; i++) begin
      tick(1'b1, i == 0, win_rand());
      tick(1'b0, 1'b0, '0);
    end
    drain();
    chk("sparse_count", np, 12);
    for (int k = 0; k < 12; k++) begin
      idx = (k < 6) ? 18 + k : 20 + k;
      chk("sparse_latency", p_cyc[k], en_cyc[idx] + 3);
    end

    // Mid-frame resync on the 5th pixel
    ne = 0; np = 0;
    for (int i = 0; i < 28; i++) tick(1'b1, i == 0 || i == 4, win_rand());
    drain();
    chk("resync_count",     np, 6);
    chk("resync_first_cyc", p_cyc[0], en_cyc[22] + 3);
    chk("resync_first_sof", p_sof[0], 1);

    // Reset mid-stream with windows in flight
    ne = 0; np = 0;
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, win_rand());
    @(posedge clk); #1;
    rst = 1'b0; en = 1'b0; sof = 1'b0; pend = 1'b0;
    for (int c = cyc; c < DEPTH; c++) begin
      exp_v[c] = 1'b0; exp_c[c] = 8'h00; exp_s[c] = 1'b0; exp_e[c] = 1'b0;
    end
    model_census = 8'h00;
    knext = 0;
    #2;
    chk("async_valid",   valid,   0);
    chk("async_census",  census,  0);
    chk("async_sof_out", sof_out, 0);
    chk("async_eol_out", eol_out, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    ne = 0; np = 0;
    for (int i = 0; i < 32; i++) tick(1'b1, 1'b0, win_rand());
    drain();
    chk("postrst_count",     np, 12);
    chk("postrst_first_cyc", p_cyc[0], en_cyc[18] + 3);
    chk("postrst_first_sof", p_sof[0], 1);

    // Frame wrap: 64 pixels without sof
    ne = 0; np = 0;
    for (int i = 0; i < 64; i++) tick(1'b1, 1'b0, win_rand());
    drain();
    chk("wrap_count", np, 24);
    j = 0;
    for (int i = 0; i < 64; i++) begin
      if ((i % 32) / LL >= NL-1 && (i % LL) >= WW-1 && j < 24) begin
        chk("wrap_pulse_cyc", p_cyc[j], en_cyc[i] + 3);
        j++;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
